serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, multi-cycle subtractor computing `a - b - b_in` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart to the team's combinational ripple-carry adders. It serves area-constrained datapaths that can tolerate WIDTH-cycle latency, such as ALU decrement paths and sequential dividers. Operands are captured on a start handshake, and results are held stable until the next operation completes.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; legal range is ≥ 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request an operation; sampled only while idle.
- `a`: input, WIDTH bits. Minuend; captured when start is accepted.
- `b`: input, WIDTH bits. Subtrahend; captured when start is accepted.
- `b_in`: input, 1 bit. Borrow-in; captured when start is accepted.
- `busy`: output, 1 bit. High while an operation is in progress; start is ignored while high.
- `done`: output, 1 bit. Single-cycle pulse marking that `diff`/`b_out` were just updated.
- `diff`: output, WIDTH bits. Result `(a - b - b_in) mod 2^WIDTH`.
- `b_out`: output, 1 bit. Borrow-out; 1 when `a < b + b_in` (unsigned).

## Operation
- State machine has two states: IDLE and SHIFT.
- **IDLE**
  - `busy` = 0.
  - If `start` = 1: load shift registers `sa` ← `a` and `sb` ← `b`, borrow flop `br` ← `b_in`, clear bit counter `cnt` ← 0, go to SHIFT.
  - If `start` = 0: remain in IDLE.
- **SHIFT**
  - `busy` = 1.
  - Each cycle, evaluate one bit with `x = sa[0]`, `y = sb[0]`:
    - difference bit `d = x ^ y ^ br`;
    - next borrow `br' = (~x & y) | (~(x ^ y) & br)`.
  - Shift `sa` and `sb` right by one. Shift `d` into the MSB of a working register `sd`.
  - Increment `cnt`.
  - On the shift where `cnt == WIDTH-1`:
    - load `diff` ← final `sd`, including this cycle's `d`;
    - load `b_out` ← `br'`;
    - assert `done` for one cycle;
    - go to IDLE.
- `diff` and `b_out` change only on that final shift. Between operations they hold their last values; `sd` is never exposed directly.
- `start` is ignored while in SHIFT (`busy` = 1). No queuing; the requester must re-assert start later.
- Arithmetic is unsigned modulo 2^WIDTH; the borrow chain is identical to a ripple subtractor.
- `cnt` is `$clog2(WIDTH)` bits wide and must not wrap before reaching WIDTH-1.

## Timing
- Reset values: `busy` = 0, `done` = 0, `diff` = 0, `b_out` = 0, state = IDLE; internal registers cleared.
- Reset has priority over all other activity. If `rst` is asserted mid-operation, the operation is aborted, no `done` is produced, outputs go to reset values on the next edge, and the block returns to IDLE.
- Latency:
  - `start` is sampled at edge k.
  - Shifts occur on edges k+1 … k+WIDTH.
  - `done`, `diff`, and `b_out` are valid in the cycle after edge k+WIDTH.
- `busy` is high in the cycles following edges k … k+WIDTH-1.
- In the `done` cycle the FSM is already in IDLE, so a `start` there is accepted. Back-to-back throughput is one operation per WIDTH+1 cycles.
- Operand inputs need to be stable only at the accepting edge.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_OVF_EN`.
- When defined:
  - adds output port `ovf` (1 bit, reset 0);
  - `ovf` = signed two's-complement overflow = (borrow into MSB) XOR (borrow out of MSB);
  - `ovf` is registered alongside `diff` and held between operations.
- When undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=4, `a`=9, `b`=3, `b_in`=0 → `done` 4 cycles after the start edge; `diff`=6, `b_out`=0.
- `a`=3, `b`=9, `b_in`=0 → `diff`=0xA, `b_out`=1. Then `a`=0, `b`=0, `b_in`=1 → `diff`=0xF, `b_out`=1.
- Start accepted with `a`=7, `b`=2; pulse `start` with other operands two cycles later while `busy` = 1 → second request ignored; `diff`=5, exactly one `done` pulse.
- Assert `rst` on the 2nd shift cycle → next cycle `busy` = 0, `diff` = 0, `b_out` = 0, no `done`. A following start with `a`=5, `b`=5 yields `diff`=0, `b_out`=0.
- Back-to-back: `start` held high continuously with `a`=12, `b`=4 → `done` every 5 cycles with `diff`=8 each time; `diff` never glitches between pulses.
- With `SERIAL_SUBTRACTOR_OVF_EN`:
  - `a`=0x8, `b`=0x1 → `diff`=0x7, `ovf`=1;
  - `a`=0x7, `b`=0x1 → `diff`=0x6, `ovf`=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop computes a - b - b_in LSB first.
// Defining SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow output `ovf`.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-2:0] sd;
   logic [WIDTH-1:0] sd_nxt;
   logic [CNT_W-1:0] cnt;
   logic             br;
   logic             d;
   logic             br_nxt;
   logic             last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      d         = sa[0] ^ sb[0] ^ br;
      br_nxt    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      // sd keeps only the WIDTH-1 bits already produced; the new bit lands on top
      sd_nxt    = {d, sd};
      last      = (cnt == LAST_CNT);
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         sd    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         b_out <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               sa  <= a;
               sb  <= b;
               br  <= b_in;
               cnt <= '0;
            end
         end else begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_nxt[WIDTH-1:1];
            br  <= br_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
               diff  <= sd_nxt;
               b_out <= br_nxt;
               done  <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               // br is the borrow into the MSB, br_nxt the borrow out of it
               ovf   <= br ^ br_nxt;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
// Build with SERIAL_SUBTRACTOR_OVF_EN defined to also exercise the ovf output.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         b_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_diff(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      int r;
      r = int'(av) - int'(bv) - int'(bi);
      return W'(r);
   endfunction

   function automatic logic model_bout(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      return (int'(av) < int'(bv) + int'(bi));
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      int s;
      s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
      return (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
   endfunction

   // Drives a one-cycle start; returns at the negedge after the accepting edge.
   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      b_in  = bi;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      b_in  = 1'($urandom);
   endtask

   // Counts negedges from the one after the accepting edge (=1) until done is seen.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      int cyc;
      logic [W-1:0] ed;
      logic eb;
      ed = model_diff(av, bv, bi);
      eb = model_bout(av, bv, bi);
      launch(av, bv, bi);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s busy after start: got %b want 1", name, busy);
      end
      wait_done(cyc);
      n_cmp++;
      if (cyc !== W + 1) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d (a=%0d b=%0d bin=%0d)", name, cyc - 1, W, av, bv, bi);
      end
      n_cmp++;
      if (diff !== ed) begin
         n_err++;
         $display("FAIL %s diff: got %h want %h (a=%h b=%h bin=%b)", name, diff, ed, av, bv, bi);
      end
      n_cmp++;
      if (b_out !== eb) begin
         n_err++;
         $display("FAIL %s b_out: got %b want %b (a=%h b=%h bin=%b)", name, b_out, eb, av, bv, bi);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_cmp++;
      if (ovf !== model_ovf(av, bv, bi)) begin
         n_err++;
         $display("FAIL %s ovf: got %b want %b (a=%h b=%h bin=%b)", name, ovf, model_ovf(av, bv, bi), av, bv, bi);
      end
`endif
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s done/busy after pulse: got %b/%b want 0/0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      b_in  = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0) begin
         n_err++;
         $display("FAIL reset outputs: got busy=%b done=%b diff=%h b_out=%b want 0/0/0/0", busy, done, diff, b_out);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset ovf: got %b want 0", ovf);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_directed();
      run_op("dir_9_3", 4'd9, 4'd3, 1'b0);
      run_op("dir_3_9", 4'd3, 4'd9, 1'b0);
      run_op("dir_0_0_bin", 4'd0, 4'd0, 1'b1);
      run_op("dir_15_15_bin", 4'd15, 4'd15, 1'b1);
      run_op("dir_15_0", 4'd15, 4'd0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
   endtask

   task automatic test_ignore_start();
      int dcount;
      launch(4'd7, 4'd2, 1'b0);
      dcount = 0;
      for (int cyc = 2; cyc <= 16; cyc++) begin
         @(negedge clk);
         if (done) dcount++;
         if (cyc == 2) begin
            start = 1'b1;
            a     = 4'd14;
            b     = 4'd1;
            b_in  = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      n_cmp++;
      if (dcount !== 1) begin
         n_err++;
         $display("FAIL ignore_start done count: got %0d want 1", dcount);
      end
      n_cmp++;
      if (diff !== 4'd5 || b_out !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_start result: got diff=%h b_out=%b want 5/0", diff, b_out);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_start idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int dcount;
      run_op("pre_reset", 4'd13, 4'd2, 1'b0);
      launch(4'd6, 4'd1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || diff !== '0 || b_out !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid outputs: got busy=%b diff=%h b_out=%b done=%b want 0/0/0/0", busy, diff, b_out, done);
      end
      dcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dcount++;
      end
      n_cmp++;
      if (dcount !== 0) begin
         n_err++;
         $display("FAIL reset_mid stray done: got %0d want 0", dcount);
      end
      run_op("post_reset_5_5", 4'd5, 4'd5, 1'b0);
   endtask

   task automatic test_back_to_back();
      int last_done;
      int dcount;
      run_op("b2b_prime", 4'd1, 4'd3, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a     = 4'd12;
      b     = 4'd4;
      b_in  = 1'b0;
      last_done = 0;
      dcount    = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         if (done) begin
            dcount++;
            n_cmp++;
            if (cyc - last_done !== W + 1) begin
               n_err++;
               $display("FAIL b2b done spacing: got %0d want %0d", cyc - last_done, W + 1);
            end
            last_done = cyc;
         end
         if (cyc >= W + 1) begin
            n_cmp++;
            if (diff !== 4'd8) begin
               n_err++;
               $display("FAIL b2b diff hold at cycle %0d: got %h want 8", cyc, diff);
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (dcount !== 6) begin
         n_err++;
         $display("FAIL b2b done count: got %0d want 6", dcount);
      end
      repeat (W + 2) @(negedge clk);
   endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   task automatic test_ovf();
      run_op("ovf_8_1", 4'h8, 4'h1, 1'b0);
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_8_1 direct: got %b want 1", ovf);
      end
      run_op("ovf_7_1", 4'h7, 4'h1, 1'b0);
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_7_1 direct: got %b want 0", ovf);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      test_ovf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
